// File: rtl/axrm_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
package axrm_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axrm_ed_calc.sv
// Two-stage exact-multiply / absolute-difference unit: S1 registers the exact
// product and the approximate product, S2 registers the error distance.
module axrm_ed_calc
  import axrm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_approx,
  output logic              ed_valid,
  output logic [PROD_W-1:0] ed
);

  logic                     s1_valid;
  logic [PROD_W-1:0]        prod_q;
  logic [PROD_W-1:0]        approx_q;
  logic signed [PROD_W:0]   diff;
  logic [PROD_W-1:0]        ed_next;

  // 17-bit signed difference so both error signs fit before taking magnitude
  assign diff    = $signed({1'b0, prod_q}) - $signed({1'b0, approx_q});
  assign ed_next = diff[PROD_W] ? PROD_W'(-diff) : PROD_W'(diff);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      prod_q   <= '0;
      approx_q <= '0;
      ed_valid <= 1'b0;
      ed       <= '0;
    end else begin
      s1_valid <= in_en;
      if (in_en) begin
        prod_q   <= PROD_W'(in_a) * PROD_W'(in_b);
        approx_q <= in_approx;
      end
      ed_valid <= s1_valid;
      if (s1_valid) ed <= ed_next;
    end
  end

endmodule

// File: rtl/axrm_error_monitor.sv
// Error-statistics monitor for approximate 8x8 multipliers over fixed-length runs.
// Define AXRM_ERRMON_SQ_EN to also accumulate the sum of squared error distances.
//
// state | meaning
// IDLE  | waiting for first start
// RUN   | accepting samples until NUM_SAMPLES taken
// FLUSH | draining the 3-stage pipeline
// DONE  | statistics valid and held until next start
module axrm_error_monitor
  import axrm_pkg::*;
#(
  parameter int NUM_SAMPLES = 256,
  parameter int ACC_W       = 32,
  localparam int LOG_N      = clog2(NUM_SAMPLES),
  localparam int CNT_W      = LOG_N + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  input  logic [PROD_W-1:0]   in_approx,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    err_count,
  output logic [ACC_W-1:0]    sum_ed,
  output logic [PROD_W-1:0]   max_ed,
  output logic [PROD_W-1:0]   mean_ed,
  output logic                acc_ovf,
  output logic [ACC_W+31:0]   sum_sq_ed
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  remain_q;
  logic [1:0]        flush_q;
  logic              accept;
  logic              run_start;
  logic              ed_valid;
  logic [PROD_W-1:0] ed;
  logic [ACC_W:0]    sum_ext;

  assign in_ready  = (state == RUN) && (remain_q != '0);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == RUN) || (state == FLUSH);
  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign sum_ext   = {1'b0, sum_ed} + {{(ACC_W + 1 - PROD_W){1'b0}}, ed};

  axrm_ed_calc u_ed_calc (
    .clk       (clk),
    .rst       (rst),
    .in_en     (accept),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_approx (in_approx),
    .ed_valid  (ed_valid),
    .ed        (ed)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && (remain_q == CNT_W'(1))) state_nx = FLUSH;
      FLUSH:   if (flush_q == 2'd0) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      remain_q <= '0;
      flush_q  <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == FLUSH) && (flush_q == 2'd0);
      if (run_start)   remain_q <= CNT_W'(NUM_SAMPLES);
      else if (accept) remain_q <= remain_q - CNT_W'(1);
      // three FLUSH cycles cover S1, S2 and the accumulate stage
      if (state == RUN && state_nx == FLUSH)    flush_q <= 2'd2;
      else if (state == FLUSH && flush_q != '0) flush_q <= flush_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
      mean_ed   <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      if (ed_valid) begin
        if (ed != '0) err_count <= err_count + CNT_W'(1);
        if (ed > max_ed) max_ed <= ed;
        if (sum_ext[ACC_W]) begin
          sum_ed  <= '1;
          acc_ovf <= 1'b1;
        end else begin
          sum_ed <= sum_ext[ACC_W-1:0];
        end
      end
      mean_ed <= acc_ovf ? '1 : PROD_W'(sum_ed >> LOG_N);
    end
  end

`ifdef AXRM_ERRMON_SQ_EN
  logic [31:0] ed_sq;
  assign ed_sq = 32'(ed) * 32'(ed);

  always_ff @(posedge clk) begin
    if (rst || run_start)  sum_sq_ed <= '0;
    else if (ed_valid)     sum_sq_ed <= sum_sq_ed + {{ACC_W{1'b0}}, ed_sq};
  end
`else
  assign sum_sq_ed = '0;
`endif

endmodule
